// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one single-port memory bus between NUM_CORES cores.
// Round-robin grant with an optional bounded lock, a fixed-latency read return
// pipeline, and per-core stall generation. Grant and bus drive are combinational
// in the request cycle; reads return RD_LATENCY cycles after issue.
module core_bus_arbiter #(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CORES-1:0]             core_req,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_wr_data,
    input  logic [NUM_CORES-1:0]             core_wr_en,
    input  logic [NUM_CORES-1:0]             core_lock,
    output logic [NUM_CORES-1:0]             core_stall,
    output logic [DATA_WIDTH-1:0]            core_rd_data,
    output logic [NUM_CORES-1:0]             core_rd_valid,
    output logic [DATA_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wr_data,
    output logic                             mem_wr_en,
    output logic                             mem_rd_en,
    input  logic [DATA_WIDTH-1:0]            mem_rd_data
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW    = IDX_W + 1;
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    localparam logic [CW-1:0]    NC_C       = CW'(NUM_CORES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CORES - 1);
    localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic             owner_vld, owner_vld_nxt;
    logic [IDX_W-1:0] owner_idx, owner_idx_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
    logic [NUM_CORES-1:0] pending, pending_nxt;

    // Read return pipeline: slot 0 is loaded at the end of the issue cycle,
    // the last slot is the return cycle.
    logic             tag_vld [RD_LATENCY];
    logic [IDX_W-1:0] tag_idx [RD_LATENCY];

    logic [NUM_CORES-1:0] eligible;
    logic             forced;
    logic             lock_hit;
    logic             rr_vld;
    logic [IDX_W-1:0] rr_idx;
    logic [CW-1:0]    cand;
    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_we;
    logic             issue_rd;
    logic             rtn_vld;

    // State registers: arbitration pointer, lock ownership, pending reads, return tags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            owner_vld <= 1'b0;
            owner_idx <= '0;
            lock_cnt  <= '0;
            pending   <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_vld[s] <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            ptr       <= ptr_nxt;
            owner_vld <= owner_vld_nxt;
            owner_idx <= owner_idx_nxt;
            lock_cnt  <= lock_cnt_nxt;
            pending   <= pending_nxt;
            tag_vld[0] <= issue_rd;
            tag_idx[0] <= grant_idx;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    // Arbitration: a still-locked, eligible owner wins unless its lock budget is spent;
    // otherwise the first eligible core at or after ptr.
    always_comb begin
        eligible = core_req & ~pending;
        forced   = owner_vld && (lock_cnt >= LOCK_MAX_C);
        lock_hit = owner_vld && !forced && core_lock[owner_idx] && eligible[owner_idx];
        rr_vld   = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= NC_C) begin
                cand = cand - NC_C;
            end
            if (!rr_vld && eligible[cand[IDX_W-1:0]]) begin
                rr_vld = 1'b1;
                rr_idx = cand[IDX_W-1:0];
            end
        end
        grant_vld = !reset && (lock_hit || rr_vld);
        grant_idx = lock_hit ? owner_idx : rr_idx;
        grant_we  = core_wr_en[grant_idx];
        issue_rd  = grant_vld && !grant_we;
        rtn_vld   = !reset && tag_vld[RD_LATENCY-1];
    end

    // Next-state: pointer advance, lock ownership/count, pending set on issue and clear on return.
    always_comb begin
        ptr_nxt = ptr;
        if (grant_vld) begin
            ptr_nxt = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end

        owner_vld_nxt = 1'b0;
        owner_idx_nxt = owner_idx;
        lock_cnt_nxt  = '0;
        if (!forced && grant_vld && core_lock[grant_idx]) begin
            owner_vld_nxt = 1'b1;
            owner_idx_nxt = grant_idx;
            if (owner_vld && owner_idx == grant_idx) begin
                lock_cnt_nxt = lock_cnt + 1'b1;
            end else begin
                lock_cnt_nxt = CNT_W'(1);
            end
        end

        pending_nxt = pending;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (issue_rd && grant_idx == IDX_W'(i)) begin
                pending_nxt[i] = 1'b1;
            end else if (core_rd_valid[i]) begin
                pending_nxt[i] = 1'b0;
            end
        end
    end

    // Outputs: bus mux from the granted core, read-return broadcast, stall per core.
    always_comb begin
        mem_addr      = '0;
        mem_wr_data   = '0;
        mem_wr_en     = 1'b0;
        mem_rd_en     = 1'b0;
        core_rd_valid = '0;
        core_stall    = '0;
        core_rd_data  = rtn_vld ? mem_rd_data : '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant_vld && grant_idx == IDX_W'(i)) begin
                mem_addr    = core_addr[i*DATA_WIDTH +: DATA_WIDTH];
                mem_wr_data = core_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                mem_wr_en   = grant_we;
                mem_rd_en   = !grant_we;
            end
            core_rd_valid[i] = rtn_vld && (tag_idx[RD_LATENCY-1] == IDX_W'(i));
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            core_stall[i] = !reset && core_req[i] &&
                            !((grant_vld && grant_we && grant_idx == IDX_W'(i)) || core_rd_valid[i]);
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: behavioural model (queues of in-flight reads, integer
// pointer/lock bookkeeping) compared every cycle, plus hand-computed directed cases.
module tb_core_bus_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int L  = 2;
    localparam int LM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      core_req, core_wr_en, core_lock;
    logic [N*DW-1:0]   core_addr, core_wr_data;
    logic [N-1:0]      core_stall, core_rd_valid;
    logic [DW-1:0]     core_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic              mem_wr_en, mem_rd_en;

    core_bus_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW), .RD_LATENCY(L), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_addr(core_addr), .core_wr_data(core_wr_data),
        .core_wr_en(core_wr_en), .core_lock(core_lock),
        .core_stall(core_stall), .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
    );

    int tests = 0;
    int fails = 0;

    // model state
    int m_ptr, m_owner, m_cnt, cyc;
    bit m_pend [N];
    int q_core [$];
    int q_due  [$];
    int m_g, m_rv;
    logic [N-1:0]  e_stall, e_rv;
    logic [DW-1:0] e_rdata, e_addr, e_wdata;
    logic          e_we, e_re;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_ptr = 0; m_owner = -1; m_cnt = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        q_core.delete(); q_due.delete();
    endtask

    task automatic model_eval();
        bit elig [N];
        bit forced;
        int c;
        m_g = -1; m_rv = -1;
        e_stall = '0; e_rv = '0; e_rdata = '0; e_addr = '0; e_wdata = '0; e_we = 1'b0; e_re = 1'b0;
        if (reset) return;
        for (int i = 0; i < N; i++) elig[i] = core_req[i] && !m_pend[i];
        forced = (m_owner >= 0) && (m_cnt >= LM);
        if (m_owner >= 0 && !forced && core_lock[m_owner] && elig[m_owner]) begin
            m_g = m_owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (m_g < 0 && elig[c]) m_g = c;
            end
        end
        for (int j = 0; j < q_due.size(); j++) if (q_due[j] == cyc) m_rv = q_core[j];
        if (m_g >= 0) begin
            e_addr  = core_addr[m_g*DW +: DW];
            e_wdata = core_wr_data[m_g*DW +: DW];
            e_we    = core_wr_en[m_g];
            e_re    = !core_wr_en[m_g];
        end
        if (m_rv >= 0) begin
            e_rv[m_rv] = 1'b1;
            e_rdata    = mem_rd_data;
        end
        for (int i = 0; i < N; i++)
            e_stall[i] = core_req[i] && !((m_g == i && core_wr_en[i]) || m_rv == i);
    endtask

    task automatic model_update();
        bit forced;
        if (reset) begin
            model_clear();
            return;
        end
        forced = (m_owner >= 0) && (m_cnt >= LM);
        if (m_rv >= 0) m_pend[m_rv] = 1'b0;
        for (int j = q_due.size() - 1; j >= 0; j--) begin
            if (q_due[j] == cyc) begin
                q_due.delete(j);
                q_core.delete(j);
            end
        end
        if (m_g >= 0) begin
            m_ptr = (m_g + 1) % N;
            if (!core_wr_en[m_g]) begin
                m_pend[m_g] = 1'b1;
                q_core.push_back(m_g);
                q_due.push_back(cyc + L);
            end
        end
        if (forced) begin
            m_owner = -1; m_cnt = 0;
        end else if (m_g >= 0 && core_lock[m_g]) begin
            if (m_g == m_owner) m_cnt++;
            else begin m_owner = m_g; m_cnt = 1; end
        end else begin
            m_owner = -1; m_cnt = 0;
        end
    endtask

    task automatic eval_check();
        @(negedge clk);
        model_eval();
        chk("stall",    32'(core_stall),    32'(e_stall));
        chk("rd_valid", 32'(core_rd_valid), 32'(e_rv));
        chk("rd_data",  core_rd_data,       e_rdata);
        chk("mem_addr", mem_addr,           e_addr);
        chk("mem_wdata", mem_wr_data,       e_wdata);
        chk("mem_wr_en", 32'(mem_wr_en),    32'(e_we));
        chk("mem_rd_en", 32'(mem_rd_en),    32'(e_re));
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        core_req = '0; core_wr_en = '0; core_lock = '0;
        core_addr = '0; core_wr_data = '0; mem_rd_data = '0;
    endtask

    // Reset with live requests so gated outputs are really exercised.
    task automatic do_reset();
        reset = 1'b1;
        core_req = '1; core_wr_en = 4'b0101; core_lock = '0;
        for (int i = 0; i < N; i++) begin
            core_addr[i*DW +: DW]    = $urandom | 32'h1;
            core_wr_data[i*DW +: DW] = $urandom;
        end
        mem_rd_data = 32'hFFFF_FFFF;
        eval_check();
        chk("rst_stall", 32'(core_stall), 32'h0);
        chk("rst_addr",  mem_addr,        32'h0);
        advance();
        reset = 1'b0;
        idle_inputs();
    endtask

    logic [3:0]  exp4;
    logic [31:0] exp042 [7];

    initial begin
        reset = 1'b1;
        idle_inputs();
        cyc = 0;
        model_clear();
        advance();

        // four cores writing continuously: grants rotate 0,1,2,3,0
        do_reset();
        core_req = '1; core_wr_en = '1;
        for (int i = 0; i < N; i++) begin
            core_addr[i*DW +: DW]    = 32'(16 * i);
            core_wr_data[i*DW +: DW] = 32'h1000 + 32'(i);
        end
        for (int k = 0; k < 5; k++) begin
            eval_check();
            exp4 = ~(4'b0001 << (k % 4));
            chk("rr_addr",  mem_addr,          32'(16 * (k % 4)));
            chk("rr_stall", 32'(core_stall),   32'(exp4));
            advance();
        end

        // single read, latency 2
        do_reset();
        core_req = 4'b0001; core_addr[31:0] = 32'h100;
        eval_check();
        chk("rd_issue_en",   32'(mem_rd_en),  32'h1);
        chk("rd_issue_addr", mem_addr,        32'h100);
        chk("rd_stall_c0",   32'(core_stall), 32'h1);
        advance();
        eval_check();
        chk("rd_stall_c1",   32'(core_stall), 32'h1);
        advance();
        mem_rd_data = 32'hDEAD_BEEF;
        eval_check();
        chk("rd_ret_valid",  32'(core_rd_valid), 32'h1);
        chk("rd_ret_data",   core_rd_data,       32'hDEAD_BEEF);
        chk("rd_ret_stall",  32'(core_stall),    32'h0);
        advance();
        idle_inputs();

        // write by core1 overlaps core0 pending read
        do_reset();
        core_req = 4'b0001; core_addr[31:0] = 32'h200;
        eval_check();
        advance();
        core_req = 4'b0011; core_wr_en = 4'b0010; core_addr[63:32] = 32'h44;
        eval_check();
        chk("ovl_wr_en",   32'(mem_wr_en), 32'h1);
        chk("ovl_wr_addr", mem_addr,       32'h44);
        advance();
        mem_rd_data = 32'h1234_5678;
        eval_check();
        chk("ovl_ret_valid", 32'(core_rd_valid), 32'h1);
        chk("ovl_ret_data",  core_rd_data,       32'h1234_5678);
        advance();
        idle_inputs();

        // lock limit: core1 locked writes vs core0
        do_reset();
        exp042 = '{32'hA0, 32'hB0, 32'hB0, 32'hB0, 32'hB0, 32'hA0, 32'hB0};
        core_req = 4'b0011; core_wr_en = 4'b0011; core_lock = 4'b0010;
        core_addr[31:0] = 32'hA0; core_addr[63:32] = 32'hB0;
        for (int k = 0; k < 7; k++) begin
            eval_check();
            chk("lock_seq", mem_addr, exp042[k]);
            advance();
        end
        idle_inputs();

        // reset during an in-flight read discards it
        do_reset();
        core_req = 4'b0001; core_addr[31:0] = 32'h300;
        eval_check();
        advance();
        reset = 1'b1;
        eval_check();
        chk("rst_mid_rd_en", 32'(mem_rd_en),  32'h0);
        chk("rst_mid_stall", 32'(core_stall), 32'h0);
        advance();
        reset = 1'b0;
        core_req = 4'b0011; core_wr_en = 4'b0011; core_addr[63:32] = 32'h310;
        eval_check();
        chk("rst_first_grant", mem_addr, 32'h300);
        advance();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            eval_check();
            chk("rst_no_ret", 32'(core_rd_valid), 32'h0);
            advance();
        end

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(199) == 0) begin
                reset = 1'b1;
                eval_check();
                advance();
                reset = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                core_req[i]   = ($urandom_range(3) != 0);
                core_wr_en[i] = $urandom_range(1);
                if ($urandom_range(9) == 0) core_lock[i] = ~core_lock[i];
                core_addr[i*DW +: DW]    = $urandom;
                core_wr_data[i*DW +: DW] = $urandom;
            end
            mem_rd_data = $urandom;
            eval_check();
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface

- REQ-001 NUM_CORES, 2, number of requesting cores; legal range 2..8.
- REQ-002 DATA_WIDTH, 32, width of the address and data buses.
- REQ-003 RD_LATENCY, 1, cycles from read issue to mem_rd_data valid; legal range 1..4.
- REQ-004 LOCK_MAX, 16, maximum consecutive locked grants to one core before forced rotation.
- REQ-005 clk  input  1  single clock; all state updates on the rising edge.
- REQ-006 reset  input  1  reset; asynchronous, active-high.
- REQ-007 core_req  input  NUM_CORES  per-core access request.
- REQ-008 core_addr  input  NUM_CORES*DATA_WIDTH  per-core address; core i occupies slice i.
- REQ-009 core_wr_data  input  NUM_CORES*DATA_WIDTH  per-core write data.
- REQ-010 core_wr_en  input  NUM_CORES  1 = write, 0 = read.
- REQ-011 core_lock  input  NUM_CORES  request to hold the grant across consecutive accesses.
- REQ-012 core_stall  output  NUM_CORES  core must hold its request and its pipeline.
- REQ-013 core_rd_data  output  DATA_WIDTH  read data, broadcast to all cores.
- REQ-014 core_rd_valid  output  NUM_CORES  one-cycle read-return strobe per core.
- REQ-015 mem_addr, mem_wr_data  output  DATA_WIDTH each  memory bus address and write data.
- REQ-016 mem_wr_en, mem_rd_en  output  1 each  memory write and read strobes.
- REQ-017 mem_rd_data  input  DATA_WIDTH  memory read data.

Function

- REQ-018 A core is eligible when core_req[i]=1 and pending[i]=0; at most one core is granted per cycle, and the grant is combinational in the same cycle.
- REQ-019 Round-robin: search eligible cores from pointer ptr upward, modulo NUM_CORES; on a grant to g, ptr <= (g+1) mod NUM_CORES; with no grant, ptr holds.
- REQ-020 Lock ownership: when a core is granted with core_lock=1, it becomes owner, and lock_cnt counts its consecutive grants.
- REQ-021 Lock priority: while the owner keeps core_lock=1 and is eligible, it wins over ptr order.
- REQ-022 Lock release: the lock is released (lock_cnt=0) when the owner drops core_lock or is not eligible.
- REQ-023 Forced rotation: when lock_cnt reaches LOCK_MAX, the next arbitration ignores the lock and uses plain round-robin from ptr; lock_cnt then resets to 0.
- REQ-024 Memory bus drive: mem_addr, mem_wr_data, mem_wr_en and mem_rd_en come from the granted core's slices.
- REQ-025 Idle bus: with no grant, mem_wr_en=0, mem_rd_en=0, mem_addr=0 and mem_wr_data=0.
- REQ-026 Write: completes in its grant cycle; core_stall[g]=0 in that cycle.
- REQ-027 Read issue: pending[g] is set at the end of the grant cycle, and a tag {valid, core index} enters an RD_LATENCY-deep shift pipeline.
- REQ-028 Read return: exactly RD_LATENCY cycles after issue, core_rd_valid[g] pulses for one cycle with core_rd_data=mem_rd_data, and pending[g] clears at the end of that cycle.
- REQ-029 Stall rule: core_stall[i] = core_req[i] AND NOT (write granted to i OR core_rd_valid[i]).
- REQ-030 Idle read data: core_rd_data=0 whenever no core_rd_valid bit is set.
- REQ-031 Re-grant spacing: the earliest re-grant of a core after its own read is the cycle after its core_rd_valid, so one core gets one read per RD_LATENCY+1 cycles.
- REQ-032 Overlap: other cores may be granted while a read is pending, so multiple reads can be in flight, at most one per pipeline slot.
- REQ-033 Dropped request: a read whose core drops core_req while pending still returns and still pulses core_rd_valid.
- REQ-034 Strobe exclusivity: at most one core_rd_valid bit is high per cycle; mem_wr_en and mem_rd_en are never both high.

Reset

- REQ-035 Reset assertion immediately clears ptr=0, lock owner, lock_cnt=0, all pending bits and all pipeline tags.
- REQ-036 While reset is asserted, every output is 0, including core_stall.
- REQ-037 Reads in flight at reset are discarded: no core_rd_valid pulses after reset deasserts.
- REQ-038 The first arbitration after deassertion starts from core 0.

Verification

- REQ-039 NUM_CORES=4, all cores write continuously with core_addr[i]=0x10*i -> grants 0,1,2,3,0; mem_addr 0x00,0x10,0x20,0x30,0x00; non-granted cores stalled.
- REQ-040 RD_LATENCY=2, core0 reads 0x100, memory returns 0xDEADBEEF two cycles later -> core_stall[0]=1 for 2 cycles, core_rd_valid[0]=1 with core_rd_data=0xDEADBEEF in cycle 2, stall 0 in that cycle.
- REQ-041 RD_LATENCY=2, core0 reads in cycle 0, core1 writes from cycle 1 -> core1 granted in cycle 1 while core0 pending; core0 return in cycle 2 is unaffected.
- REQ-042 LOCK_MAX=4, core1 locked continuous writes, core0 requesting -> core1 granted 4 consecutive cycles, core0 granted in cycle 5.
- REQ-043 Reset asserted 1 cycle after core0 read issue (RD_LATENCY=3) -> all outputs 0 immediately, no core_rd_valid afterwards, first post-reset grant goes to core0.
